// File: rtl/gpp16_pkg.sv
// Shared definitions for the 16-bit pipeline: ALU func codes, instruction layout and the
// operation record that travels from operand fetch to the ALU.
package gpp16_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  localparam logic [4:0] FUNC_ADD = 5'd0;
  localparam logic [4:0] FUNC_SUB = 5'd1;
  localparam logic [4:0] FUNC_MUL = 5'd2;
  localparam logic [4:0] FUNC_DIV = 5'd3;
  localparam logic [4:0] FUNC_MOD = 5'd4;

  localparam int FUNC_LSB = 11;
  localparam int RD_LSB   = 8;
  localparam int RA_LSB   = 5;
  localparam int RB_LSB   = 2;
  localparam int IMM_BIT  = 1;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [4:0] func;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       imm_sel;
    logic       rsvd;
  } instr_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    func;
    logic [2:0]    rd;
  } issue_t;

endpackage

// File: rtl/regfile_16.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, and a same-cycle write-to-read bypass.
module regfile_16 #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // The bypass lets an op issue in the very cycle its source is written back.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

endmodule

// File: rtl/opfetch_16.sv
// Operand-fetch/issue stage: decodes an instruction, reads operands, stalls on scoreboard
// hazards and hands {a, b, func, rd} to the ALU through a one-deep valid/ready register.
module opfetch_16
  import gpp16_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [4:0]    out_func,
  output logic [2:0]    out_rd,
  input  logic          wb_en,
  input  logic [2:0]    wb_addr,
  input  logic [DW-1:0] wb_data
);

  // Handshake: a transfer happens on any edge where valid & ready are both high; a producer
  // holding valid keeps its payload stable until that edge, and ready never depends on valid.
  instr_t          ins;
  logic            unused_rsvd;
  logic [DW-1:0]   rdata_a, rdata_b, opb;
  logic [NREG-1:0] pend_q, pend_d, pend_post, wb_clr;
  logic            hazard, accept;
  logic            valid_q, valid_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [4:0]      func_q, func_d;
  logic [2:0]      rd_q, rd_d;

  assign ins         = instr_t'(in_instr);
  assign unused_rsvd = ins.rsvd;

  regfile_16 #(.DW(DW), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (ins.ra),
    .raddr_b_i (ins.rb),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  assign opb = ins.imm_sel ? {{(DW-3){1'b0}}, ins.rb} : rdata_b;

  // Hazards use the post-writeback scoreboard so a same-cycle writeback releases the stall.
  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_addr] = 1'b1;
    pend_post = pend_q & ~wb_clr;
    hazard = ((ins.ra != '0) & pend_post[ins.ra])
           | ((ins.rb != '0) & ~ins.imm_sel & pend_post[ins.rb])
           | ((ins.rd != '0) & pend_post[ins.rd]);
  end

  assign in_ready = (~valid_q | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  always_comb begin
    pend_d  = pend_post;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    rd_d    = rd_q;
    if (accept) begin
      if (ins.rd != '0) pend_d[ins.rd] = 1'b1;
      valid_d = 1'b1;
      a_d     = rdata_a;
      b_d     = opb;
      func_d  = ins.func;
      rd_d    = ins.rd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      rd_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_func  = func_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_opfetch_16.sv
// Directed bench for opfetch_16: a per-cycle vector table plus hand-written reset sequences.
module tb_opfetch_16;
  import gpp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [15:0] in_instr, out_a, out_b, wb_data;
  logic [4:0]  out_func;
  logic [2:0]  out_rd, wb_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  opfetch_16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_func(out_func), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic        vld;
    logic [15:0] instr;
    logic        ordy;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        exp_rdy;
    logic        exp_ov;
    logic        chk;
    issue_t      exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] mk(input logic [4:0] f, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic imm);
    return {f, rd, ra, rb, imm, 1'b0};
  endfunction

  task automatic add(input logic vld, input logic [15:0] instr, input logic ordy,
                     input logic wen, input logic [2:0] waddr, input logic [15:0] wdata,
                     input logic exp_rdy, input logic exp_ov, input logic chk,
                     input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                     input logic [2:0] rd);
    vec_t v;
    v.vld = vld; v.instr = instr; v.ordy = ordy; v.wen = wen; v.waddr = waddr;
    v.wdata = wdata; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.chk = chk;
    v.exp.a = a; v.exp.b = b; v.exp.func = f; v.exp.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [15:0] instr, input logic ordy,
                       input logic wen, input logic [2:0] waddr, input logic [15:0] wdata);
    in_valid = vld; in_instr = instr; out_ready = ordy;
    wb_en = wen; wb_addr = waddr; wb_data = wdata;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // vld instr                         ordy wen addr data     rdy ov chk a        b        f  rd
    add(1, mk(FUNC_ADD,1,0,0,0),          1,  0,  0, 16'h0,    1,  1, 1, 16'h0,    16'h0,    0, 1);
    add(0, 16'h0,                         1,  1,  2, 16'h1234, 1,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_SUB,3,2,5,1),          1,  0,  0, 16'h0,    1,  1, 1, 16'h1234, 16'h0005, 1, 3);
    add(1, mk(FUNC_MUL,4,0,0,0),          1,  0,  0, 16'h0,    1,  1, 1, 16'h0,    16'h0,    2, 4);
    add(1, mk(FUNC_ADD,5,4,0,0),          1,  0,  0, 16'h0,    0,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_ADD,5,4,0,0),          1,  0,  0, 16'h0,    0,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_ADD,5,4,0,0),          1,  1,  4, 16'h00AA, 1,  1, 1, 16'h00AA, 16'h0,    0, 5);
    for (int i = 0; i < 5; i++)
      add(1, mk(FUNC_DIV,6,2,2,0),        0,  0,  0, 16'h0,    0,  1, 1, 16'h00AA, 16'h0,    0, 5);
    add(1, mk(FUNC_DIV,6,2,2,0),          1,  0,  0, 16'h0,    1,  1, 1, 16'h1234, 16'h1234, 3, 6);
    add(1, mk(FUNC_MOD,7,2,3,1),          1,  0,  0, 16'h0,    1,  1, 1, 16'h1234, 16'h0003, 4, 7);
    add(1, mk(FUNC_SUB,2,2,2,0),          1,  0,  0, 16'h0,    1,  1, 1, 16'h1234, 16'h1234, 1, 2);
    add(1, mk(FUNC_ADD,0,0,0,0),          1,  1,  0, 16'hFFFF, 1,  1, 1, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_ADD,0,0,0,0),          1,  0,  0, 16'h0,    1,  1, 1, 16'h0,    16'h0,    0, 0);
    add(0, 16'h0,                         1,  0,  0, 16'h0,    1,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_ADD,3,0,0,0),          1,  0,  0, 16'h0,    0,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_ADD,3,0,0,0),          1,  1,  3, 16'h0033, 1,  1, 1, 16'h0,    16'h0,    0, 3);
    add(1, mk(FUNC_SUB,0,3,0,0),          1,  0,  0, 16'h0,    0,  0, 0, 16'h0,    16'h0,    0, 0);
    add(1, mk(FUNC_SUB,0,3,0,0),          1,  1,  3, 16'h0044, 1,  1, 1, 16'h0044, 16'h0,    1, 0);

    // Reset state
    rst_n = 1'b0;
    drive(0, 16'h0, 1, 0, 0, 16'h0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].instr, vecs[i].ordy, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_out_a", i), 32'(out_a), 32'(vecs[i].exp.a));
        chk($sformatf("v%0d_out_b", i), 32'(out_b), 32'(vecs[i].exp.b));
        chk($sformatf("v%0d_out_func", i), 32'(out_func), 32'(vecs[i].exp.func));
        chk($sformatf("v%0d_out_rd", i), 32'(out_rd), 32'(vecs[i].exp.rd));
      end
    end

    // Reset in the middle of a stall on r4
    @(negedge clk);
    drive(1, mk(FUNC_ADD,4,0,0,0), 1, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    chk("mid_set_pend_ov", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(1, mk(FUNC_SUB,5,4,0,0), 1, 0, 0, 16'h0);
    #1;
    chk("mid_stall_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_a", 32'(out_a), 32'd0);
    chk("post_rst_out_rd", 32'(out_rd), 32'd5);
    @(negedge clk);
    drive(0, 16'h0, 1, 0, 0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
